mean_pool_div_ctrl: RTL

- Upstream feeder and result collector for the sequential fixed-point divider in the CNN datapath.
- Accumulates a stream of unsigned fixed-point activations, which forms one pooling window terminated by in_last.
- Issues one divide of sum by sample count, waits for the divider, and presents the window mean on a valid/ready output.
- Used for average pooling and global-average-pool layers.

---
 rtl/mean_pool_div_ctrl_if.sv | 40 ++++
 rtl/mean_pool_div_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/mean_pool_div_ctrl_if.sv
// Bundles the sample stream, the result stream and the divider handshake of the
// mean-pool divide controller. The controller takes the slave view.
interface mean_pool_div_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_sat;
    logic             out_dbz;
    logic             out_ovf;

    logic             div_start;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             div_busy;
    logic             div_valid;
    logic             div_dbz;
    logic             div_ovf;
    logic [WIDTH-1:0] div_q;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
               div_busy, div_valid, div_dbz, div_ovf, div_q,
        output in_ready, out_valid, out_data, out_sat, out_dbz, out_ovf,
               div_start, div_x, div_y
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
               div_busy, div_valid, div_dbz, div_ovf, div_q,
        input  in_ready, out_valid, out_data, out_sat, out_dbz, out_ovf,
               div_start, div_x, div_y
    );
endinterface

// File: rtl/mean_pool_div_ctrl.sv
// Average-pool window accumulator: saturating sum of a sample window, one divide of
// sum by (count << FBITS) on the external sequential divider, mean on valid/ready.
module mean_pool_div_ctrl #(
    parameter int WIDTH = 16,
    parameter int FBITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mean_pool_div_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {ACC, START, WAIT, OUT} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sum, count;
    logic             sat;

    logic             accept, capture, handshake;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sum_nxt, count_nxt;
    logic             in_ready_d, div_start_d, out_valid_d;

    // in_ready mirrors state==ACC, so acceptance needs only the state.
    assign accept    = (state == ACC) && bus.in_valid;
    assign capture   = (state == WAIT) && !bus.div_busy;
    assign handshake = bus.out_valid && bus.out_ready;

    assign add_full  = {1'b0, sum} + {1'b0, bus.in_data};
    assign sum_nxt   = add_full[WIDTH] ? {WIDTH{1'b1}} : add_full[WIDTH-1:0];
    assign count_nxt = count + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            ACC:     if (accept && bus.in_last) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (capture) state_d = OUT;
            OUT:     if (handshake) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Registered outputs are decoded one cycle early; out_valid lags entry to OUT
    // by one cycle so the captured result is settled in its register first.
    always_comb begin
        in_ready_d  = (state_d == ACC);
        div_start_d = (state_d == START);
        out_valid_d = (state == OUT) && !handshake;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum           <= '0;
            count         <= '0;
            sat           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sat   <= 1'b0;
            bus.out_dbz   <= 1'b0;
            bus.out_ovf   <= 1'b0;
            bus.div_start <= 1'b0;
            bus.div_x     <= '0;
            bus.div_y     <= '0;
        end else begin
            bus.in_ready  <= in_ready_d;
            bus.div_start <= div_start_d;
            bus.out_valid <= out_valid_d;
            if (accept) begin
                sum   <= sum_nxt;
                count <= count_nxt;
                sat   <= sat | add_full[WIDTH];
                if (bus.in_last) begin
                    bus.div_x <= sum_nxt;
                    bus.div_y <= count_nxt << FBITS;
                end
            end
            if (capture) begin
                bus.out_data <= (bus.div_dbz || bus.div_ovf) ? '0 : bus.div_q;
                bus.out_dbz  <= bus.div_dbz;
                bus.out_ovf  <= bus.div_ovf;
                bus.out_sat  <= sat;
                sum          <= '0;
                count        <= '0;
                sat          <= 1'b0;
            end
        end
    end
endmodule
